// File: rtl/pong_pkg.sv
// Shared types and court constants for the pong paddle datapath.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } lane_state_t;

  // Request encoding is {down, up}; both or neither means no motion.
  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10,
    DIR_BOTH = 2'b11
  } dir_t;

  localparam int COURT_MAX_X       = 640;
  localparam int COURT_MAX_Y       = 480;
  localparam int COURT_EDGE_OFFSET = 8;

endpackage

// File: rtl/paddle_lane.sv
// One paddle: direction FSM, speed ramp and saturating position update.
// PADDLE_AI_EN adds a ball-tracking request source selected by ai_sel.
module paddle_lane
  import pong_pkg::*;
#(
  parameter int BIT_WIDTH     = 10,
  parameter int MAX_Y         = COURT_MAX_Y,
  parameter int PADDLE_LENGTH = 64,
  parameter int EDGE_OFFSET   = COURT_EDGE_OFFSET,
  parameter int MIN_SPEED     = 2,
  parameter int MAX_SPEED     = 8,
`ifdef PADDLE_AI_EN
  parameter int AI_DEADBAND   = 4,
`endif
  parameter int ACCEL         = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 pause,
  input  logic [1:0]           dy,
`ifdef PADDLE_AI_EN
  input  logic                 ai_sel,
  input  logic [BIT_WIDTH-1:0] ball_y,
`endif
  output logic [BIT_WIDTH-1:0] paddle_y,
  output logic                 moving,
  output logic                 at_wall
);

  localparam int Y_LO  = EDGE_OFFSET;
  localparam int Y_HI  = MAX_Y - PADDLE_LENGTH;
  localparam int Y_RST = (MAX_Y - PADDLE_LENGTH) / 2;

  localparam logic signed [BIT_WIDTH:0] Y_LO_S = (BIT_WIDTH+1)'(Y_LO);
  localparam logic signed [BIT_WIDTH:0] Y_HI_S = (BIT_WIDTH+1)'(Y_HI);

  function automatic logic [BIT_WIDTH-1:0] clamp_y(input logic signed [BIT_WIDTH:0] v);
    if (v > Y_HI_S)      return BIT_WIDTH'(Y_HI);
    else if (v < Y_LO_S) return BIT_WIDTH'(Y_LO);
    else                 return v[BIT_WIDTH-1:0];
  endfunction

  function automatic logic out_of_range(input logic signed [BIT_WIDTH:0] v);
    return (v > Y_HI_S) || (v < Y_LO_S);
  endfunction

  lane_state_t                 state_p1, state_n;
  logic        [BIT_WIDTH-1:0] speed_p1, speed_n, speed_ramp;
  logic        [BIT_WIDTH-1:0] y_p1, y_n;
  logic                        moving_p1, at_wall_p1;
  logic signed [BIT_WIDTH:0]   y_raw;
  dir_t                        req;

`ifdef PADDLE_AI_EN
  logic [BIT_WIDTH+1:0] centre, ball_ext;
  dir_t                 ai_req;

  // Track the ball with the paddle centre, holding still inside the dead zone.
  always_comb begin
    centre   = {2'b00, y_p1} + (BIT_WIDTH+2)'(PADDLE_LENGTH / 2);
    ball_ext = {2'b00, ball_y};
    if (ball_ext > centre + (BIT_WIDTH+2)'(AI_DEADBAND))
      ai_req = DIR_UP;
    else if (ball_ext + (BIT_WIDTH+2)'(AI_DEADBAND) < centre)
      ai_req = DIR_DN;
    else
      ai_req = DIR_NONE;
  end
`endif

  // Stage p0 -> p1: next state, ramped speed and clamped position
  always_comb begin
    req = dir_t'(dy);
`ifdef PADDLE_AI_EN
    if (ai_sel) req = ai_req;
`endif
    speed_ramp = speed_p1 + BIT_WIDTH'(ACCEL);
    if (speed_ramp > BIT_WIDTH'(MAX_SPEED)) speed_ramp = BIT_WIDTH'(MAX_SPEED);

    state_n = IDLE;
    speed_n = '0;
    y_raw   = $signed({1'b0, y_p1});
    case (req)
      DIR_UP: begin
        state_n = UP;
        speed_n = (state_p1 == UP) ? speed_ramp : BIT_WIDTH'(MIN_SPEED);
        y_raw   = $signed({1'b0, y_p1}) + $signed({1'b0, speed_n});
      end
      DIR_DN: begin
        state_n = DN;
        speed_n = (state_p1 == DN) ? speed_ramp : BIT_WIDTH'(MIN_SPEED);
        y_raw   = $signed({1'b0, y_p1}) - $signed({1'b0, speed_n});
      end
      default: ;
    endcase

    y_n = clamp_y(y_raw);
    // Hitting a wall restarts the ramp but keeps the direction.
    if (out_of_range(y_raw)) speed_n = BIT_WIDTH'(MIN_SPEED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1   <= IDLE;
      speed_p1   <= '0;
      y_p1       <= BIT_WIDTH'(Y_RST);
      moving_p1  <= 1'b0;
      at_wall_p1 <= 1'b0;
    end else if (tick && !pause) begin
      state_p1   <= state_n;
      speed_p1   <= speed_n;
      y_p1       <= y_n;
      moving_p1  <= (state_n != IDLE);
      at_wall_p1 <= (y_n == BIT_WIDTH'(Y_LO)) || (y_n == BIT_WIDTH'(Y_HI));
    end
  end

  assign paddle_y = y_p1;
  assign moving   = moving_p1;
  assign at_wall  = at_wall_p1;

endmodule

// File: rtl/paddle_array.sv
// Multi-paddle motion controller: NUM_PADDLES independent lanes, flat outputs.
// Define PADDLE_AI_EN to add the ai_sel/ball_y ball-tracking mode.
module paddle_array
  import pong_pkg::*;
#(
  parameter int BIT_WIDTH     = 10,
  parameter int NUM_PADDLES   = 2,
  parameter int MAX_X         = COURT_MAX_X,
  parameter int MAX_Y         = COURT_MAX_Y,
  parameter int PADDLE_LENGTH = 64,
  parameter int PADDLE_WIDTH  = 8,
  parameter int EDGE_OFFSET   = COURT_EDGE_OFFSET,
  parameter int MIN_SPEED     = 2,
  parameter int MAX_SPEED     = 8,
  parameter int ACCEL         = 2,
`ifdef PADDLE_AI_EN
  parameter int AI_DEADBAND   = 4,
`endif
  parameter logic [7:0] SIDE_MASK = 8'b10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tick,
  input  logic                             pause,
  input  logic [2*NUM_PADDLES-1:0]         dy,
`ifdef PADDLE_AI_EN
  input  logic [NUM_PADDLES-1:0]           ai_sel,
  input  logic [BIT_WIDTH-1:0]             ball_y,
`endif
  output logic [BIT_WIDTH*NUM_PADDLES-1:0] paddle_x,
  output logic [BIT_WIDTH*NUM_PADDLES-1:0] paddle_y,
  output logic [NUM_PADDLES-1:0]           moving,
  output logic [NUM_PADDLES-1:0]           at_wall
);

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_lane
    // Left-wall paddles sit just inside x = 0, right-wall ones just inside MAX_X.
    localparam int X_POS = SIDE_MASK[i] ? (PADDLE_WIDTH + 1) : (MAX_X - PADDLE_WIDTH - 1);

    assign paddle_x[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(X_POS);

    paddle_lane #(
      .BIT_WIDTH    (BIT_WIDTH),
      .MAX_Y        (MAX_Y),
      .PADDLE_LENGTH(PADDLE_LENGTH),
      .EDGE_OFFSET  (EDGE_OFFSET),
      .MIN_SPEED    (MIN_SPEED),
      .MAX_SPEED    (MAX_SPEED),
`ifdef PADDLE_AI_EN
      .AI_DEADBAND  (AI_DEADBAND),
`endif
      .ACCEL        (ACCEL)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .pause   (pause),
      .dy      (dy[2*i +: 2]),
`ifdef PADDLE_AI_EN
      .ai_sel  (ai_sel[i]),
      .ball_y  (ball_y),
`endif
      .paddle_y(paddle_y[i*BIT_WIDTH +: BIT_WIDTH]),
      .moving  (moving[i]),
      .at_wall (at_wall[i])
    );
  end

endmodule

// File: tb/tb_paddle_array.sv
// Scoreboard bench for paddle_array: randomized and directed frames against a behavioural model.
module tb_paddle_array;

  localparam int BW = 10;
  localparam int NP = 2;
  localparam int YLO = 8;
  localparam int YHI = 480 - 64;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               tick = 1'b0;
  logic               pause = 1'b0;
  logic [2*NP-1:0]    dy = '1;
  logic [NP-1:0]      ai_sel = '0;
  logic [BW-1:0]      ball_y = '0;
  logic [BW*NP-1:0]   paddle_x, paddle_y;
  logic [NP-1:0]      moving, at_wall;

  always #5 clk = ~clk;

  paddle_array dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .pause   (pause),
    .dy      (dy),
`ifdef PADDLE_AI_EN
    .ai_sel  (ai_sel),
    .ball_y  (ball_y),
`endif
    .paddle_x(paddle_x),
    .paddle_y(paddle_y),
    .moving  (moving),
    .at_wall (at_wall)
  );

  typedef struct {
    logic [BW*NP-1:0] y;
    logic [NP-1:0]    mv;
    logic [NP-1:0]    aw;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Behavioural model: y, speed and direction (0 none, 1 up, -1 down) per paddle.
  int my[NP];
  int ms[NP];
  int mdir[NP];

  localparam logic [BW*NP-1:0] EXP_X = {10'd9, 10'd631};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      my[i] = 208;
      ms[i] = 0;
      mdir[i] = 0;
    end
  endtask

  task automatic model_tick(input logic [2*NP-1:0] d, input logic [NP-1:0] ai, input int by);
    for (int i = 0; i < NP; i++) begin
      int want, c, ny;
      want = (d[2*i +: 2] == 2'b01) ? 1 : (d[2*i +: 2] == 2'b10) ? -1 : 0;
      if (ai[i]) begin
        c = my[i] + 32;
        want = (by > c + 4) ? 1 : (by + 4 < c) ? -1 : 0;
      end
      if (want == 0) begin
        ms[i] = 0;
      end else begin
        ms[i] = (want == mdir[i]) ? ((ms[i] + 2 > 8) ? 8 : ms[i] + 2) : 2;
        ny = my[i] + want * ms[i];
        if (ny > YHI) begin ny = YHI; ms[i] = 2; end
        if (ny < YLO) begin ny = YLO; ms[i] = 2; end
        my[i] = ny;
      end
      mdir[i] = want;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < NP; i++) begin
      e.y[i*BW +: BW] = BW'(my[i]);
      e.mv[i] = (mdir[i] != 0);
      e.aw[i] = (my[i] == YLO) || (my[i] == YHI);
    end
    return e;
  endfunction

  // Inputs change on the falling edge; the expected post-edge state is queued.
  task automatic drive(input logic [2*NP-1:0] d, input logic t, input logic p);
    @(negedge clk);
    dy = d;
    tick = t;
    pause = p;
    if (t && !p) model_tick(d, ai_sel, int'(ball_y));
    sb.push_back(model_out());
  endtask

  task automatic frame(input logic [2*NP-1:0] d, input logic p);
    drive(d, 1'b1, p);
    drive(d, 1'b0, 1'b0);
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pop one expectation per registered output update.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("paddle_y", paddle_y, mon_e.y);
      check("moving", moving, mon_e.mv);
      check("at_wall", at_wall, mon_e.aw);
      check("paddle_x", paddle_x, EXP_X);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", sb.size());
    $fatal(1);
  end

  initial begin
    model_reset();
    #12;
    check("rst_x", paddle_x, EXP_X);
    check("rst_y", paddle_y, {10'd208, 10'd208});
    check("rst_moving", moving, 0);
    check("rst_at_wall", at_wall, 0);
    @(negedge clk);
    rst = 1'b1;

    // Hold up on lane 0 for five frames.
    repeat (5) frame(4'b1101, 1'b0);
    drain();
    check("ramp_y0", paddle_y[9:0], 236);
    check("ramp_y1", paddle_y[19:10], 208);

    // Line lane 0 up so a full-speed step lands on 410, then hit the top wall.
    frame(4'b1111, 1'b0);
    frame(4'b1101, 1'b0);
    frame(4'b1111, 1'b0);
    repeat (23) frame(4'b1101, 1'b0);
    drain();
    check("pre_wall_y0", paddle_y[9:0], 410);
    frame(4'b1101, 1'b0);
    drain();
    check("wall_y0", paddle_y[9:0], 416);
    check("wall_flag0", at_wall[0], 1);
    repeat (3) frame(4'b1101, 1'b0);
    drain();
    check("wall_hold_y0", paddle_y[9:0], 416);

    // Lane 1 down to speed 6, then reverse.
    repeat (3) frame(4'b1000, 1'b0);
    frame(4'b0100, 1'b0);
    drain();
    check("reverse_y1", paddle_y[19:10], 198);

    // Pause while holding up, then resume with the held speed ramped.
    repeat (2) frame(4'b0100, 1'b0);
    repeat (3) frame(4'b0100, 1'b1);
    drain();
    check("pause_y1", paddle_y[19:10], 208);
    frame(4'b0100, 1'b0);
    drain();
    check("resume_y1", paddle_y[19:10], 216);

    // Randomized frames with random gaps and pauses.
    for (int k = 0; k < 250; k++) begin
      logic [2*NP-1:0] d;
      for (int i = 0; i < NP; i++) d[2*i +: 2] = 2'($urandom_range(0, 3));
      drive(d, 1'b1, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) drive(2'($urandom_range(0, 3)) == 0 ? '1 : d, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-frame.
    drain();
    #1;
    rst = 1'b0;
    #1;
    check("async_y", paddle_y, {10'd208, 10'd208});
    check("async_moving", moving, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    frame(4'b1101, 1'b0);
    drain();
    check("post_rst_y0", paddle_y[9:0], 210);

`ifdef PADDLE_AI_EN
    // AI lane 0 chases ball_y = 400 and ignores its dy request.
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    ai_sel = 2'b01;
    ball_y = 10'd400;
    repeat (30) frame(4'b1110, 1'b0);
    drain();
    check("ai_y0", paddle_y[9:0], 364);
    check("ai_moving0", moving[0], 0);
    ai_sel = '0;
`endif

    repeat (2) drain();
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
